div: RTL and testbench

Multi-cycle 32-bit signed/unsigned divider that feeds the execute stage for DIV/DIVU. Execute launches a division, stalls the pipeline until ready_o, then writes remainder to HI and quotient to LO. Radix-2 restoring algorithm: 32 iterations, one quotient bit per cycle, fully registered outputs.

---
 rtl/div_pkg.sv | 38 +++
 rtl/div_if.sv | 23 ++
 rtl/div.sv | 147 ++++++++++++++
 tb/tb_div.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encodings and sign helpers for the
// multi-cycle restoring divider.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic [REG_BUS-1:0]        ZERO_WORD   = 32'h0000_0000;
  localparam logic [DOUBLE_REG_BUS-1:0] ZERO_DOUBLE = 64'h0000_0000_0000_0000;
  localparam logic                      RST_ENABLE  = 1'b1;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [5:0] DIV_ITERATIONS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Two's-complement negate when en is set; wraps mod 2^32.
  function automatic logic [REG_BUS-1:0] negate_if(input logic [REG_BUS-1:0] v,
                                                   input logic en);
    logic [REG_BUS-1:0] r;
    if (en) begin
      r = ZERO_WORD - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_if.sv
// Execute-stage <-> divider handshake bundle.
interface div_if;
  import div_pkg::*;

  logic                      signed_div_i;
  logic [REG_BUS-1:0]        opdata1_i;
  logic [REG_BUS-1:0]        opdata2_i;
  logic                      start_i;
  logic                      annul_i;
  logic [DOUBLE_REG_BUS-1:0] result_o;
  logic                      ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// Radix-2 restoring 32-bit signed/unsigned divider; one quotient bit per
// cycle, result {remainder, quotient} held until execute drops start.
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  div_state_e                r_state, w_state_nxt;
  logic [5:0]                r_cnt, w_cnt_nxt;
  logic [REG_BUS-1:0]        r_dividend, w_dividend_nxt;
  logic [REG_BUS-1:0]        r_divisor, w_divisor_nxt;
  logic [DOUBLE_REG_BUS-1:0] r_work, w_work_nxt;
  logic                      r_signed, w_signed_nxt;
  logic                      r_sign1, w_sign1_nxt;
  logic                      r_sign2, w_sign2_nxt;
  logic [DOUBLE_REG_BUS-1:0] r_result, w_result_nxt;
  logic                      r_ready, w_ready_nxt;

  logic [REG_BUS:0]          w_partial;
  logic                      w_ge;
  logic [REG_BUS-1:0]        w_trial;
  logic [REG_BUS-1:0]        w_quo_fix;
  logic [REG_BUS-1:0]        w_rem_fix;

  // Remainder is always below the divisor, so the difference fits in 32 bits.
  assign w_partial = {r_work[63:32], r_dividend[31]};
  assign w_ge      = (w_partial >= {1'b0, r_divisor});
  assign w_trial   = w_partial[31:0] - r_divisor;

  assign w_quo_fix = negate_if(r_work[31:0], r_signed & (r_sign1 ^ r_sign2));
  assign w_rem_fix = negate_if(r_work[63:32], r_signed & r_sign1);

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_work_nxt     = r_work;
    w_signed_nxt   = r_signed;
    w_sign1_nxt    = r_sign1;
    w_sign2_nxt    = r_sign2;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;
    case (r_state)
      DIV_FREE: begin
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        w_result_nxt = ZERO_DOUBLE;
        if ((bus.start_i == DIV_START) && !bus.annul_i) begin
          if (bus.opdata2_i == ZERO_WORD) begin
            w_state_nxt = DIV_BY_ZERO;
          end else begin
            w_dividend_nxt = negate_if(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[31]);
            w_divisor_nxt  = negate_if(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[31]);
            w_signed_nxt   = bus.signed_div_i;
            w_sign1_nxt    = bus.opdata1_i[31];
            w_sign2_nxt    = bus.opdata2_i[31];
            w_cnt_nxt      = 6'd0;
            w_work_nxt     = ZERO_DOUBLE;
            w_state_nxt    = DIV_ON;
          end
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        w_work_nxt  = ZERO_DOUBLE;
        w_state_nxt = DIV_END;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = ZERO_DOUBLE;
        end else if (r_cnt != DIV_ITERATIONS) begin
          if (w_ge) begin
            w_work_nxt = {w_trial, r_work[30:0], 1'b1};
          end else begin
            w_work_nxt = {w_partial[31:0], r_work[30:0], 1'b0};
          end
          w_dividend_nxt = {r_dividend[30:0], 1'b0};
          w_cnt_nxt      = r_cnt + 6'd1;
        end else begin
          w_work_nxt  = {w_rem_fix, w_quo_fix};
          w_cnt_nxt   = 6'd0;
          w_state_nxt = DIV_END;
        end
      end
      DIV_END: begin
        // annul is deliberately ignored here: the result is already committed.
        if (bus.start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = ZERO_DOUBLE;
        end else begin
          w_ready_nxt  = DIV_RESULT_READY;
          w_result_nxt = r_work;
        end
      end
      default: begin
        w_state_nxt  = DIV_FREE;
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        w_result_nxt = ZERO_DOUBLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_cnt      <= 6'd0;
      r_dividend <= ZERO_WORD;
      r_divisor  <= ZERO_WORD;
      r_work     <= ZERO_DOUBLE;
      r_signed   <= 1'b0;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_result   <= ZERO_DOUBLE;
      r_ready    <= DIV_RESULT_NOT_READY;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_work     <= w_work_nxt;
      r_signed   <= w_signed_nxt;
      r_sign1    <= w_sign1_nxt;
      r_sign2    <= w_sign2_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected {result, ready edge},
// a negedge monitor pops and compares on each rising ready_o.
module tb_div;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic prev_ready;

  typedef struct {
    logic [63:0] res;
    int          edge_no;
  } exp_t;

  exp_t sb_q[$];

  div_if bus ();

  div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every rising ready_o against the scoreboard head.
  always @(negedge clk) begin
    prev_ready <= bus.ready_o;
    if (bus.ready_o === 1'b1 && prev_ready !== 1'b1 && rst === 1'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", bus.result_o, e.res);
        check("latency_edge", 64'(cyc), 64'(e.edge_no));
      end
    end
  end

  task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input int lat, input int hold);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    e.res     = exp_res;
    e.edge_no = cyc + 1 + lat;
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) begin
        got = 1'b1;
      end else if (i == 5) begin
        bus.opdata1_i    = 32'hDEAD_BEEF;
        bus.opdata2_i    = 32'h0000_0000;
        bus.signed_div_i = ~sgn;
      end
    end
    if (!got) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, "_hold_result"}, bus.result_o, exp_res);
      check({name, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_drop_ready"}, 64'(bus.ready_o), 64'd0);
    check({name, "_drop_result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    logic [1:0] st;
    int         hi_cnt;
    n_checks         = 0;
    n_fail           = 0;
    cyc              = 0;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    st = u_dut.r_state;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_state", 64'(st), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 5);
    do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, 0);
    do_div("s_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 0);
    do_div("dbz", 1'b0, 32'd1234, 32'd0, 64'd0, 2, 0);
    do_div("sdbz", 1'b1, 32'hFFFFFF00, 32'd0, 64'd0, 2, 0);
    do_div("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34, 0);
    do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 0);
    do_div("u_big", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h00000001_00000001, 34, 0);

    // start with annul in the idle state is ignored
    @(posedge clk); #1;
    bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1; bus.annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    st = u_dut.r_state;
    check("start_annul_state", 64'(st), 64'd0);
    check("start_annul_ready", 64'(bus.ready_o), 64'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;

    // annul at iteration 10 of 50/5
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    @(negedge clk);
    st = u_dut.r_state;
    check("annul_state", 64'(st), 64'd0);
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    hi_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) hi_cnt++;
    end
    check("annul_no_ready", 64'(hi_cnt), 64'd0);
    do_div("after_annul", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 34, 0);

    // reset in the middle of iteration 20
    @(posedge clk); #1;
    bus.signed_div_i = 1'b1; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1; bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    st = u_dut.r_state;
    check("midrst_state", 64'(st), 64'd0);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    do_div("after_rst", 1'b1, 32'd50, 32'd5, 64'h00000000_0000000A, 34, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
